// File: rtl/move_stream_if.sv
// Output stream of move_stream: one board position per beat under valid/ready.
//   master (producer): out_valid, board_out, white_to_move_out, castle_mask_out,
//                      en_passant_col_out, out_index, out_last; samples out_ready
//   slave  (consumer): the mirror image, drives out_ready
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 16
`endif

interface move_stream_if #(
  parameter int unsigned BOARD_WIDTH = `PIECE_BITS * 64,
  parameter int unsigned INDEX_WIDTH = $clog2(`MAX_POSITIONS)
);
  logic                   out_valid;
  logic                   out_ready;
  logic [BOARD_WIDTH-1:0] board_out;
  logic                   white_to_move_out;
  logic [3:0]             castle_mask_out;
  logic [3:0]             en_passant_col_out;
  logic [INDEX_WIDTH-1:0] out_index;
  logic                   out_last;

  modport master (
    output out_valid,
    output board_out,
    output white_to_move_out,
    output castle_mask_out,
    output en_passant_col_out,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  board_out,
    input  white_to_move_out,
    input  castle_mask_out,
    input  en_passant_col_out,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/move_stream.sv
// Walks a move generator's RAM of legal positions and streams every entry
// downstream as one valid/ready beat, then pulses clear_moves to release the
// generator for the next list.
//   clk, reset        : clock, synchronous active-high reset
//   moves_ready       : generator holds a valid list of move_count entries
//   move_index        : RAM read address (2-cycle read: ADDR + WAIT)
//   board_in, white_to_move_in, castle_mask_in, en_passant_col_in : RAM data
//   clear_moves       : one-cycle pulse after the last beat (or an empty list)
//   busy              : high whenever the scanner is not IDLE
//   out_if            : output beat stream (board copy, index, last flag)
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 16
`endif

module move_stream #(
  parameter int unsigned PIECE_WIDTH        = `PIECE_BITS,
  parameter int unsigned SIDE_WIDTH         = PIECE_WIDTH * 8,
  parameter int unsigned BOARD_WIDTH        = PIECE_WIDTH * 64,
  parameter int unsigned MAX_POSITIONS      = `MAX_POSITIONS,
  parameter int unsigned MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
  input  logic [BOARD_WIDTH-1:0]        board_in,
  input  logic                          white_to_move_in,
  input  logic [3:0]                    castle_mask_in,
  input  logic [3:0]                    en_passant_col_in,
  output logic [MAX_POSITIONS_LOG2-1:0] move_index,
  output logic                          clear_moves,
  output logic                          busy,
  move_stream_if.master                 out_if
);

  localparam int unsigned IDX_W = MAX_POSITIONS_LOG2;
  // One extra bit so index+1 never wraps when the list fills the index range.
  localparam int unsigned CNT_W = MAX_POSITIONS_LOG2 + 1;
  localparam int unsigned RANKS = BOARD_WIDTH / SIDE_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ADDR       = 3'd1,
    S_WAIT       = 3'd2,
    S_PRESENT    = 3'd3,
    S_CLEAR      = 3'd4,
    S_CLEAR_WAIT = 3'd5
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] count_d;
  logic [IDX_W-1:0] index_d;
  logic [IDX_W-1:0] count_in_c;
  logic [CNT_W-1:0] next_index_c;
  logic             more_c;
  logic             last_c;
  logic             xfer_c;

  // A list longer than the RAM cannot be addressed; clamp it to the RAM depth.
  assign count_in_c   = (CNT_W'(move_count) > CNT_W'(MAX_POSITIONS)) ?
                        IDX_W'(MAX_POSITIONS) : move_count;
  assign next_index_c = CNT_W'(move_index) + CNT_W'(1);
  assign more_c       = next_index_c < CNT_W'(count_q);
  assign last_c       = next_index_c == CNT_W'(count_q);
  assign xfer_c       = out_if.out_valid && out_if.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, next read address and count latch.
  always_comb begin
    state_d = state_q;
    index_d = move_index;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        index_d = '0;
        if (moves_ready) begin
          count_d = count_in_c;
          state_d = (count_in_c != '0) ? S_ADDR : S_CLEAR;
        end
      end
      S_ADDR: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (xfer_c) begin
          if (more_c) begin
            index_d = move_index + IDX_W'(1);
            state_d = S_ADDR;
          end else begin
            index_d = '0;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_CLEAR_WAIT;
      end
      S_CLEAR_WAIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered control outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_index       <= '0;
      count_q          <= '0;
      clear_moves      <= 1'b0;
      busy             <= 1'b0;
      out_if.out_valid <= 1'b0;
    end else begin
      move_index       <= index_d;
      count_q          <= count_d;
      clear_moves      <= (state_d == S_CLEAR);
      busy             <= (state_d != S_IDLE);
      out_if.out_valid <= (state_d == S_PRESENT);
    end
  end

  // Beat payload: captured from RAM on WAIT->PRESENT, held until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_if.board_out          <= '0;
      out_if.white_to_move_out  <= 1'b0;
      out_if.castle_mask_out    <= 4'd0;
      out_if.en_passant_col_out <= 4'd0;
      out_if.out_index          <= '0;
      out_if.out_last           <= 1'b0;
    end else if (state_q == S_WAIT) begin
      for (int unsigned r = 0; r < RANKS; r++) begin
        out_if.board_out[r*SIDE_WIDTH +: SIDE_WIDTH] <= board_in[r*SIDE_WIDTH +: SIDE_WIDTH];
      end
      out_if.white_to_move_out  <= white_to_move_in;
      out_if.castle_mask_out    <= castle_mask_in;
      out_if.en_passant_col_out <= en_passant_col_in;
      out_if.out_index          <= move_index;
      out_if.out_last           <= last_c;
    end
  end

endmodule

// File: doc/move_stream.md
MOVE_STREAM -- requirements
Module: move_stream

Interface
REQ-001 Parameter PIECE_WIDTH, default `PIECE_BITS, bits per square.
REQ-002 Parameter SIDE_WIDTH, default PIECE_WIDTH*8, bits per rank.
REQ-003 Parameter BOARD_WIDTH, default PIECE_WIDTH*64, bits per board.
REQ-004 Parameter MAX_POSITIONS, default `MAX_POSITIONS, move RAM depth.
REQ-005 Parameter MAX_POSITIONS_LOG2, default $clog2(`MAX_POSITIONS), index width.
REQ-006 Single clock, clk; reset is synchronous and active-high, named reset.
REQ-007 clk  in  1  clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 moves_ready  in  1  move generator has a valid move list.
REQ-010 move_count  in  MAX_POSITIONS_LOG2  number of legal moves in list.
REQ-011 board_in  in  BOARD_WIDTH  board read from move RAM at move_index.
REQ-012 white_to_move_in  in  1  side-to-move of the read entry.
REQ-013 castle_mask_in  in  4  castle mask of the read entry.
REQ-014 en_passant_col_in  in  4  en-passant column of the read entry.
REQ-015 move_index  out  MAX_POSITIONS_LOG2  move RAM read address.
REQ-016 clear_moves  out  1  one-cycle pulse releasing the move generator.
REQ-017 out_valid  out  1  output beat valid.
REQ-018 out_ready  in  1  downstream accepts beat.
REQ-019 board_out, white_to_move_out, castle_mask_out[3:0], en_passant_col_out[3:0]  out  registered copy of entry.
REQ-020 out_index  out  MAX_POSITIONS_LOG2  index of the entry presented.
REQ-021 out_last  out  1  presented entry is index move_count-1.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 States SHALL be IDLE, ADDR, WAIT, PRESENT, CLEAR, CLEAR_WAIT.
REQ-024 IDLE: move_index=0; on moves_ready, latch move_count into count_q; go ADDR if count_q nonzero, else CLEAR.
REQ-025 Move RAM read latency SHALL be treated as 2 cycles: ADDR holds move_index one cycle, WAIT one cycle, then *_in sampled on WAIT->PRESENT transition.
REQ-026 On entry to PRESENT, outputs SHALL load from *_in, out_index=move_index, out_last=(move_index+1==count_q), out_valid=1.
REQ-027 PRESENT: outputs SHALL hold stable while out_valid && !out_ready.
REQ-028 Beat transfers on the cycle out_valid && out_ready; out_valid drops next cycle.
REQ-029 After transfer: if move_index+1 < count_q, move_index increments and state goes ADDR; else state goes CLEAR.
REQ-030 Comparison move_index+1 < count_q SHALL be computed at MAX_POSITIONS_LOG2+1 bits (no wrap at full list).
REQ-031 CLEAR: clear_moves=1 for exactly one cycle; go CLEAR_WAIT.
REQ-032 CLEAR_WAIT: one cycle, ignore moves_ready; go IDLE.
REQ-033 moves_ready asserted outside IDLE SHALL be ignored; count_q unchanged.
REQ-034 move_count changes after latch SHALL not affect current scan.
REQ-035 Throughput: one beat per 3 cycles with out_ready tied high.

Reset
REQ-036 reset SHALL force IDLE on the next clk edge from any state, abandoning any scan.
REQ-037 Reset values: move_index=0, clear_moves=0, out_valid=0, out_last=0, out_index=0, busy=0, board_out=0, white_to_move_out=0, castle_mask_out=0, en_passant_col_out=0.
REQ-038 No clear_moves pulse SHALL be generated as a result of reset.

Verification
REQ-039 move_count=3, out_ready=1 -> beats with out_index 0,1,2, out_last only on 2, one clear_moves pulse, busy low after CLEAR_WAIT.
REQ-040 move_count=0 -> no out_valid, clear_moves pulses 1 cycle after moves_ready sampled.
REQ-041 move_count=2, out_ready low 10 cycles on beat 0 -> board_out/out_index stable all 10 cycles, beat 1 follows.
REQ-042 move_count=MAX_POSITIONS-1 with distinct board_in per index -> every index delivered once, data matches RAM model with 2-cycle latency.
REQ-043 reset asserted in PRESENT of beat 1 of 4 -> next cycle all outputs at reset values, no clear_moves; fresh moves_ready restarts at index 0.
REQ-044 moves_ready toggled during scan -> scan count and sequence unaffected.
